// File: rtl/fir_pkg.sv
// Shared types and default geometry for the 64-tap FIR sequencer.
package fir_pkg;
  localparam int NTAPS_D = 64;
  localparam int NSAMP_D = 16384;
  localparam int CAW_D   = 6;
  localparam int IAW_D   = 14;
  localparam int PIPE_D  = 2;

  typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, OUT, DONE} state_t;
endpackage

// File: rtl/fir_ctrl_if.sv
// Host strobes in, memory/MAC controls out; master = host side, slave = sequencer.
interface fir_ctrl_if import fir_pkg::*; #(
  parameter int CAW = CAW_D,
  parameter int IAW = IAW_D
);
  logic           s;
  logic           cload;
  logic           dload;
  logic [IAW-1:0] addr;
  logic           cmem_we;
  logic [CAW-1:0] cmem_addr;
  logic           imem_we;
  logic [IAW-1:0] imem_addr;
  logic           data_zero;
  logic           acc_clr;
  logic           acc_en;
  logic           valid;
  logic           done;
  logic           busy;

  modport master (
    output s, cload, dload, addr,
    input  cmem_we, cmem_addr, imem_we, imem_addr, data_zero,
           acc_clr, acc_en, valid, done, busy
  );

  modport slave (
    input  s, cload, dload, addr,
    output cmem_we, cmem_addr, imem_we, imem_addr, data_zero,
           acc_clr, acc_en, valid, done, busy
  );
endinterface

// File: rtl/fir_addr_gen.sv
// Output-sample (n) and tap (k) counters with the x[n-k] read address.
module fir_addr_gen import fir_pkg::*; #(
  parameter int NTAPS = NTAPS_D,
  parameter int NSAMP = NSAMP_D,
  parameter int CAW   = CAW_D,
  parameter int IAW   = IAW_D
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_k,
  input  logic           inc_k,
  input  logic           clr_n,
  input  logic           inc_n,
  output logic [CAW-1:0] k,
  output logic [IAW-1:0] rd_addr,
  output logic           data_zero,
  output logic           last_tap,
  output logic           last_samp
);
  logic [IAW-1:0] n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        k <= '0;
    else if (clr_k) k <= '0;
    else if (inc_k) k <= last_tap ? '0 : k + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        n <= '0;
    else if (clr_n) n <= '0;
    else if (inc_n) n <= n + 1'b1;
  end

  // Early taps of the first samples wrap the subtraction; data_zero tells the datapath to ignore them.
  assign rd_addr   = n - IAW'(k);
  assign data_zero = IAW'(k) > n;
  assign last_tap  = (k == CAW'(NTAPS - 1));
  assign last_samp = (n == IAW'(NSAMP - 1));
endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer: host load muxing in IDLE, then CLR/MAC/DRAIN/OUT per output sample.
module fir_ctrl import fir_pkg::*; #(
  parameter int NTAPS = NTAPS_D,
  parameter int NSAMP = NSAMP_D,
  parameter int CAW   = CAW_D,
  parameter int IAW   = IAW_D,
  parameter int PIPE  = PIPE_D
) (
  input  logic       clk,
  input  logic       rst,
  fir_ctrl_if.slave  bus
);
  localparam int DW = $clog2(PIPE + 1);

  state_t          state, state_n;
  logic [DW-1:0]   dcnt;
  logic [PIPE-1:0] vld_pipe;
  logic            vld_p0;
  logic [CAW-1:0]  k;
  logic [IAW-1:0]  rd_addr;
  logic            data_zero, last_tap, last_samp, last_drain;

  logic           cmem_we, imem_we, acc_clr, valid, done;
  logic [CAW-1:0] cmem_addr;
  logic [IAW-1:0] imem_addr;
  logic           dz;

  fir_addr_gen #(.NTAPS(NTAPS), .NSAMP(NSAMP), .CAW(CAW), .IAW(IAW)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr_k     (state == CLR),
    .inc_k     (state == MAC),
    .clr_n     (state_n == IDLE),
    .inc_n     ((state == OUT) && bus.s && !last_samp),
    .k         (k),
    .rd_addr   (rd_addr),
    .data_zero (data_zero),
    .last_tap  (last_tap),
    .last_samp (last_samp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dcnt <= '0;
    else if (state == DRAIN) dcnt <= dcnt + 1'b1;
    else                     dcnt <= '0;
  end

  assign last_drain = (dcnt == DW'(PIPE - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.s && bus.cload && bus.dload) state_n = CLR;
      CLR:     state_n = bus.s ? MAC : IDLE;
      MAC:     if (!bus.s) state_n = IDLE; else if (last_tap) state_n = DRAIN;
      DRAIN:   if (!bus.s) state_n = IDLE; else if (last_drain) state_n = OUT;
      OUT:     if (!bus.s) state_n = IDLE; else state_n = last_samp ? DONE : CLR;
      DONE:    if (!bus.s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmem_we   = 1'b0;
    cmem_addr = '0;
    imem_we   = 1'b0;
    imem_addr = '0;
    dz        = 1'b0;
    acc_clr   = 1'b0;
    valid     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (!rst) begin
        // Coefficient strobe has priority when both loads arrive together.
        cmem_we   = !bus.cload;
        cmem_addr = !bus.cload ? bus.addr[CAW-1:0] : '0;
        imem_we   = !bus.dload && bus.cload;
        imem_addr = !bus.dload ? bus.addr : '0;
      end
      CLR:  acc_clr = 1'b1;
      MAC: begin
        cmem_addr = k;
        imem_addr = rd_addr;
        dz        = data_zero;
      end
      OUT:  valid = bus.s;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: tap issued from MAC; acc_en is the issue flag PIPE cycles later.
  assign vld_p0 = (state == MAC) && bus.s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  vld_pipe <= '0;
    else if (state_n == IDLE) vld_pipe <= '0;
    else                      vld_pipe <= (vld_pipe << 1) | PIPE'(vld_p0);
  end

  assign bus.cmem_we   = cmem_we;
  assign bus.cmem_addr = cmem_addr;
  assign bus.imem_we   = imem_we;
  assign bus.imem_addr = imem_addr;
  assign bus.data_zero = dz;
  assign bus.acc_clr   = acc_clr;
  assign bus.acc_en    = vld_pipe[PIPE-1];
  assign bus.valid     = valid;
  assign bus.done      = done;
  assign bus.busy      = (state != IDLE);
endmodule
